lut_share_arbiter: RTL and testbench

- Shares one interpolating r^2→force-factor LUT core between NUM_PE processing elements.
- Grants at most one PE request per cycle using round-robin arbitration, tags the request, and routes the 1-cycle LUT result back to the requester.
- Sequences LUT (re)configuration from a base/slope stream. Lookups are blocked while a load is in progress and until the first full load completes.

---
 rtl/lut_share_arbiter_if.sv | 21 ++
 rtl/lut_share_arbiter.sv | 151 +++++++++++++++
 tb/tb_lut_share_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_share_arbiter_if.sv
// PE-side request/response bundle for lut_share_arbiter.
// PEs drive through the master modport; the arbiter connects through slave.
interface lut_share_arbiter_if #(
  parameter int NUM_PE = 4
);
  logic [NUM_PE-1:0]    pe_req_valid;
  logic [16*NUM_PE-1:0] pe_req_code;
  logic [NUM_PE-1:0]    pe_req_ready;
  logic [NUM_PE-1:0]    pe_resp_valid;
  logic [15:0]          pe_resp_data;

  modport master (
    output pe_req_valid, pe_req_code,
    input  pe_req_ready, pe_resp_valid, pe_resp_data
  );

  modport slave (
    input  pe_req_valid, pe_req_code,
    output pe_req_ready, pe_resp_valid, pe_resp_data
  );
endinterface

// File: rtl/lut_share_arbiter.sv
// Round-robin sharing of one interpolating LUT core between NUM_PE PEs, plus config sequencing.
// Optional grant/stall counters are enabled with `define LUT_SHARE_STATS_EN.
module lut_share_arbiter #(
  parameter int NUM_PE    = 4,
  parameter int SEG_BITS  = 8,
  parameter int LUT_DEPTH = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  lut_share_arbiter_if.slave  pe,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  input  logic [15:0]         cfg_base,
  input  logic [15:0]         cfg_slope,
  output logic                cfg_ready,
  output logic                cfg_done,
  output logic                lut_loaded,
  output logic                lut_req_valid,
  output logic [15:0]         lut_r2_code,
  output logic                lut_conf_wr_en,
  output logic [SEG_BITS-1:0] lut_conf_addr,
  output logic [15:0]         lut_conf_base,
  output logic [15:0]         lut_conf_slope,
  input  logic [15:0]         lut_data_in,
  input  logic                lut_ready_in
`ifdef LUT_SHARE_STATS_EN
  ,
  output logic [31:0]         stat_grants,
  output logic [31:0]         stat_stalls
`endif
);
  localparam int unsigned N = NUM_PE;
  localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [PTR_W-1:0]    LAST_PE   = PTR_W'(NUM_PE - 1);
  localparam logic [SEG_BITS-1:0] LAST_ADDR = SEG_BITS'(LUT_DEPTH - 1);

  typedef enum logic [1:0] {RUN, DRAIN, CONFIG} state_t;

  state_t              state;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    gnt_idx;
  logic [PTR_W-1:0]    cand_idx;
  logic [PTR_W-1:0]    tag_idx;
  logic                tag_valid;
  logic                gnt;
  logic [SEG_BITS-1:0] cfg_addr;
  logic [15:0]         codes [NUM_PE];

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      codes[i] = pe.pe_req_code[16*i +: 16];
    end
  end

  // First requester at or above rr_ptr (with wrap); cfg_start suppresses any grant.
  always_comb begin
    gnt      = 1'b0;
    gnt_idx  = '0;
    cand_idx = '0;
    if (state == RUN && lut_loaded && !cfg_start) begin
      for (int unsigned i = 0; i < N; i++) begin
        cand_idx = PTR_W'((32'(rr_ptr) + i) % N);
        if (!gnt && pe.pe_req_valid[cand_idx]) begin
          gnt     = 1'b1;
          gnt_idx = cand_idx;
        end
      end
    end
  end

  always_comb begin
    pe.pe_req_ready = '0;
    lut_req_valid   = gnt;
    lut_r2_code     = '0;
    if (gnt) begin
      pe.pe_req_ready = NUM_PE'(1) << gnt_idx;
      lut_r2_code     = codes[gnt_idx];
    end
  end

  always_comb begin
    cfg_ready      = (state == CONFIG);
    lut_conf_wr_en = (state == CONFIG) && cfg_valid;
    lut_conf_addr  = lut_conf_wr_en ? cfg_addr  : '0;
    lut_conf_base  = lut_conf_wr_en ? cfg_base  : '0;
    lut_conf_slope = lut_conf_wr_en ? cfg_slope : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= RUN;
      rr_ptr           <= '0;
      tag_valid        <= 1'b0;
      tag_idx          <= '0;
      cfg_addr         <= '0;
      cfg_done         <= 1'b0;
      lut_loaded       <= 1'b0;
      pe.pe_resp_valid <= '0;
      pe.pe_resp_data  <= '0;
    end else begin
      cfg_done         <= 1'b0;
      pe.pe_resp_valid <= '0;
      if (tag_valid && lut_ready_in) begin
        pe.pe_resp_valid <= NUM_PE'(1) << tag_idx;
        pe.pe_resp_data  <= lut_data_in;
      end

      // A grant refills the tag in the same edge the previous one retires.
      if (gnt) begin
        tag_valid <= 1'b1;
        tag_idx   <= gnt_idx;
        rr_ptr    <= (gnt_idx == LAST_PE) ? '0 : gnt_idx + 1'b1;
      end else if (lut_ready_in) begin
        tag_valid <= 1'b0;
      end

      case (state)
        RUN:    if (cfg_start) state <= DRAIN;
        DRAIN:  if (!tag_valid) state <= CONFIG;
        CONFIG: begin
          if (cfg_valid) begin
            if (cfg_addr == LAST_ADDR) begin
              cfg_addr   <= '0;
              cfg_done   <= 1'b1;
              lut_loaded <= 1'b1;
              state      <= RUN;
            end else begin
              cfg_addr <= cfg_addr + 1'b1;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef LUT_SHARE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else if (cfg_start) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      if (gnt && stat_grants != '1) stat_grants <= stat_grants + 32'd1;
      if ((|pe.pe_req_valid) && !gnt && stat_stalls != '1) stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_lut_share_arbiter.sv
// Directed + randomized bench for lut_share_arbiter against a cycle-level behavioural model.
// Includes a stand-in LUT core that interpolates base + slope*frac/256 from its written table.
module tb_lut_share_arbiter;
  localparam int NPE   = 4;
  localparam int SB    = 8;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lut_share_arbiter_if #(.NUM_PE(NPE)) pif ();

  logic          cfg_start, cfg_valid;
  logic [15:0]   cfg_base, cfg_slope;
  logic          cfg_ready, cfg_done, lut_loaded;
  logic          lut_req_valid;
  logic [15:0]   lut_r2_code;
  logic          lut_conf_wr_en;
  logic [SB-1:0] lut_conf_addr;
  logic [15:0]   lut_conf_base, lut_conf_slope;
  logic [15:0]   lut_data_in;
  logic          lut_ready_in;

  lut_share_arbiter #(.NUM_PE(NPE), .SEG_BITS(SB), .LUT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pe(pif),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_base(cfg_base), .cfg_slope(cfg_slope),
    .cfg_ready(cfg_ready), .cfg_done(cfg_done), .lut_loaded(lut_loaded),
    .lut_req_valid(lut_req_valid), .lut_r2_code(lut_r2_code),
    .lut_conf_wr_en(lut_conf_wr_en), .lut_conf_addr(lut_conf_addr),
    .lut_conf_base(lut_conf_base), .lut_conf_slope(lut_conf_slope),
    .lut_data_in(lut_data_in), .lut_ready_in(lut_ready_in)
  );

  function automatic logic [15:0] interp(int b, int s, logic [7:0] f);
    int p;
    p = s * int'({24'b0, f});
    return 16'(b + (p >>> 8));
  endfunction

  // Stand-in LUT core: one-cycle lookup from whatever the arbiter wrote.
  int core_base [DEPTH];
  int core_slope [DEPTH];
  always @(posedge clk) begin
    if (lut_conf_wr_en) begin
      core_base[lut_conf_addr]  <= int'($signed(lut_conf_base));
      core_slope[lut_conf_addr] <= int'($signed(lut_conf_slope));
    end
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_ready_in <= 1'b0;
      lut_data_in  <= '0;
    end else begin
      lut_ready_in <= lut_req_valid;
      lut_data_in  <= interp(core_base[lut_r2_code[15:8]], core_slope[lut_r2_code[15:8]], lut_r2_code[7:0]);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: phase 0 = serving lookups, 1 = waiting for in-flight lookup, 2 = loading.
  int   m_base [DEPTH];
  int   m_slope [DEPTH];
  int   m_ptr, m_phase, m_cnt;
  bit   m_loaded, m_done;
  bit   s1_v, s2_v;
  int   s1_g, s2_g;
  logic [15:0] s1_d, s2_d;
  int   grant_log[$];
  logic [15:0] resp_data_log[$];
  logic [NPE-1:0] resp_vec_log[$];
  int   done_cnt = 0;

  function automatic logic [15:0] m_interp(logic [15:0] code);
    return interp(m_base[code[15:8]], m_slope[code[15:8]], code[7:0]);
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_phase = 0; m_cnt = 0; m_loaded = 0; m_done = 0;
    s1_v = 0; s2_v = 0; s1_g = 0; s2_g = 0; s1_d = '0; s2_d = '0;
  endtask

  task automatic cycle();
    int g;
    bit wr, prev_s1;
    logic [NPE-1:0] e_rdy;
    logic [15:0] e_code;
    @(negedge clk);
    g = -1;
    if (m_phase == 0 && m_loaded && !cfg_start)
      for (int k = 0; k < NPE; k++)
        if (g < 0 && pif.pe_req_valid[(m_ptr + k) % NPE]) g = (m_ptr + k) % NPE;
    e_rdy  = '0;
    e_code = '0;
    if (g >= 0) begin
      e_rdy[g] = 1'b1;
      e_code   = pif.pe_req_code[16*g +: 16];
    end
    chk("req_ready", pif.pe_req_ready, e_rdy);
    chk("lut_req_valid", lut_req_valid, g >= 0);
    chk("lut_r2_code", lut_r2_code, e_code);
    chk("resp_valid", pif.pe_resp_valid, s2_v ? (1 << s2_g) : 0);
    if (s2_v) chk("resp_data", pif.pe_resp_data, s2_d);
    wr = (m_phase == 2) && cfg_valid;
    chk("cfg_ready", cfg_ready, m_phase == 2);
    chk("conf_wr_en", lut_conf_wr_en, wr);
    if (wr) begin
      chk("conf_addr", lut_conf_addr, m_cnt);
      chk("conf_base", lut_conf_base, cfg_base);
      chk("conf_slope", lut_conf_slope, cfg_slope);
    end
    chk("cfg_done", cfg_done, m_done);
    chk("lut_loaded", lut_loaded, m_loaded);
    if (g >= 0) grant_log.push_back(g);
    if (pif.pe_resp_valid != '0) begin
      resp_data_log.push_back(pif.pe_resp_data);
      resp_vec_log.push_back(pif.pe_resp_valid);
    end
    if (cfg_done === 1'b1) done_cnt++;

    prev_s1 = s1_v;
    s2_v = s1_v; s2_g = s1_g; s2_d = s1_d;
    s1_v = (g >= 0);
    if (g >= 0) begin
      s1_g  = g;
      s1_d  = m_interp(e_code);
      m_ptr = (g + 1) % NPE;
    end
    m_done = 0;
    case (m_phase)
      0: if (cfg_start) m_phase = 1;
      1: if (!prev_s1) m_phase = 2;
      default: if (cfg_valid) begin
        m_base[m_cnt]  = int'($signed(cfg_base));
        m_slope[m_cnt] = int'($signed(cfg_slope));
        m_cnt++;
        if (m_cnt == DEPTH) begin
          m_cnt = 0; m_phase = 0; m_loaded = 1; m_done = 1;
        end
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_req_ready", pif.pe_req_ready, 0);
    chk("rst_resp_valid", pif.pe_resp_valid, 0);
    chk("rst_resp_data", pif.pe_resp_data, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_cfg_done", cfg_done, 0);
    chk("rst_lut_loaded", lut_loaded, 0);
    chk("rst_lut_req_valid", lut_req_valid, 0);
    chk("rst_lut_r2_code", lut_r2_code, 0);
    chk("rst_conf_wr_en", lut_conf_wr_en, 0);
    chk("rst_conf_addr", lut_conf_addr, 0);
    chk("rst_conf_base", lut_conf_base, 0);
    chk("rst_conf_slope", lut_conf_slope, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Pulse cfg_start, then stream entries spaced by `gap` idle cycles; stop_at >= 0 abandons the pass there.
  task automatic config_pass(int gap, bit rnd, int stop_at);
    int e = 0, guard = 0, idle;
    bit acc;
    idle = gap;
    cfg_start = 1'b1; cfg_valid = 1'b0;
    cycle();
    cfg_start = 1'b0;
    while (e < DEPTH && guard < 4000) begin
      guard++;
      if (m_phase == 2 && e == stop_at) begin
        cfg_valid = 1'b0;
        return;
      end
      cfg_valid = (m_phase == 2) && (idle >= gap);
      cfg_base  = rnd ? 16'($urandom) : 16'(e);
      cfg_slope = rnd ? 16'($urandom) : 16'h0000;
      acc = cfg_valid;
      cycle();
      if (acc) begin e++; idle = 0; end else idle++;
    end
    cfg_valid = 1'b0;
    chk("cfg_pass_entries", e, DEPTH);
  endtask

  task automatic rand_traffic(int n, bit with_cfg);
    for (int i = 0; i < n; i++) begin
      pif.pe_req_valid = NPE'($urandom);
      pif.pe_req_code  = {$urandom, $urandom};
      cfg_start = with_cfg && ($urandom_range(0, 149) == 0);
      cfg_valid = with_cfg && ($urandom_range(0, 1) == 1);
      cfg_base  = 16'($urandom);
      cfg_slope = 16'($urandom);
      cycle();
    end
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_before;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    pif.pe_req_valid = '0;
    pif.pe_req_code  = '0;
    cfg_start = 1'b0; cfg_valid = 1'b0; cfg_base = '0; cfg_slope = '0;
    model_reset();
    #1;
    do_reset();

    // Requests before any load are never granted.
    pif.pe_req_valid = 4'b1111;
    pif.pe_req_code  = {16'h0800, 16'h0700, 16'h0600, 16'h0500};
    repeat (10) cycle();
    chk("no_grant_unloaded", grant_log.size(), 0);

    // First full load with base = address, slope = 0.
    pif.pe_req_valid = '0;
    config_pass(0, 1'b0, -1);
    cycle();
    chk("done_pulses", done_cnt, 1);
    chk("loaded_after_pass", lut_loaded, 1);

    // All PEs requesting: round-robin order and 2-cycle response latency.
    grant_log.delete();
    resp_data_log.delete();
    pif.pe_req_valid = 4'b1111;
    repeat (8) cycle();
    for (int k = 0; k < 5; k++) chk($sformatf("rr_order%0d", k), grant_log[k], exp_order[k]);
    chk("resp_0500", resp_data_log[0], 16'h0005);
    chk("resp_0600", resp_data_log[1], 16'h0006);

    // After the PE3 grant, a lone PE2 request wraps around; pointer then sits at 3.
    pif.pe_req_valid = 4'b0100;
    cycle();
    chk("wrap_grant", grant_log[$], 2);
    pif.pe_req_valid = 4'b1111;
    cycle();
    chk("ptr_after_wrap", grant_log[$], 3);

    // cfg_start right after a PE1 grant: response still delivered, no grants while loading.
    pif.pe_req_valid = 4'b0010;
    cycle();
    chk("pe1_grant", grant_log[$], 1);
    n_before = grant_log.size();
    resp_vec_log.delete();
    pif.pe_req_valid = 4'b1111;
    config_pass(3, 1'b1, -1);
    chk("no_grants_during_cfg", grant_log.size(), n_before);
    chk("pe1_resp_delivered", resp_vec_log[1], 4'b0010);

    rand_traffic(400, 1'b0);

    // Reset part-way through a load discards it.
    pif.pe_req_valid = '0;
    config_pass(0, 1'b1, 100);
    do_reset();
    n_before = grant_log.size();
    pif.pe_req_valid = 4'b1111;
    repeat (10) cycle();
    chk("blocked_after_midcfg_reset", grant_log.size(), n_before);
    config_pass(0, 1'b1, -1);
    rand_traffic(800, 1'b1);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
